// File: rtl/tis_acc_unit.sv
// tis_acc_unit: TIS-100 node execution stage.
// Gathers one operand, drives the ALU, saturates into ACC/BAK.
module tis_alu #(
  parameter int W = 12
) (
  input  logic [1:0]   code_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  always_comb begin
    unique case (code_i)
      2'b01:   y_o = a_i + b_i;
      2'b10:   y_o = a_i - b_i;
      2'b11:   y_o = -a_i;
      default: y_o = b_i;
    endcase
  end
endmodule

module tis_acc_unit #(
  parameter int N     = 11,
  parameter int LIMIT = 999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op,
  input  logic         src_imm,
  input  logic [0:N-1] imm,
  input  logic [0:N-1] port_data,
  input  logic         port_valid,
  output logic         port_ready,
  output logic [0:N-1] acc,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_p,
  output logic         done
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT_PORT,
    EXEC
  } state_e;

  localparam logic [2:0] OpMov = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpNeg = 3'b100;
  localparam logic [2:0] OpSwp = 3'b101;
  localparam logic [2:0] OpSav = 3'b110;

  localparam logic signed [N:0] LimP = LIMIT[N:0];
  localparam logic signed [N:0] LimN = -LimP;

  state_e       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [0:N-1] opnd_q, opnd_d;
  logic [0:N-1] acc_q, acc_d;
  logic [0:N-1] bak_q, bak_d;
  logic         done_q;

  logic         needs_port;
  logic [1:0]   code;
  logic [N:0]   alu_a, alu_b, alu_y;
  logic [0:N-1] sat;

  assign needs_port = !src_imm &&
    (op == OpMov || op == OpAdd || op == OpSub);

  always_comb begin
    code = 2'b00;
    unique case (1'b1)
      op_q == OpAdd: code = 2'b01;
      op_q == OpSub: code = 2'b10;
      op_q == OpNeg: code = 2'b11;
      default:       code = 2'b00;
    endcase
  end

  assign alu_a = {acc_q[0], acc_q};
  assign alu_b = {opnd_q[0], opnd_q};

  tis_alu #(.W(N + 1)) u_alu (
    .code_i (code),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .y_o    (alu_y)
  );

  // Widened result always fits N+1 bits, so one compare per bound suffices
  always_comb begin
    if ($signed(alu_y) > LimP)
      sat = LimP[N-1:0];
    else if ($signed(alu_y) < LimN)
      sat = LimN[N-1:0];
    else
      sat = alu_y[N-1:0];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    bak_d   = bak_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d    = op;
          opnd_d  = imm;
          state_d = needs_port ? WAIT_PORT : EXEC;
        end
      end
      WAIT_PORT: begin
        if (port_valid) begin
          opnd_d  = port_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        unique case (1'b1)
          op_q == OpMov,
          op_q == OpAdd,
          op_q == OpSub,
          op_q == OpNeg: acc_d = sat;
          op_q == OpSwp: begin
            acc_d = bak_q;
            bak_d = acc_q;
          end
          op_q == OpSav: bak_d = acc_q;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      bak_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      bak_q   <= bak_d;
      done_q  <= (state_q == EXEC);
    end
  end

  assign op_ready   = (state_q == IDLE);
  assign port_ready = (state_q == WAIT_PORT);
  assign acc        = acc_q;
  assign done       = done_q;
  assign flag_z     = (acc_q == '0);
  assign flag_n     = acc_q[0];
  assign flag_p     = !flag_z && !flag_n;
endmodule

// File: tb/tb_tis_acc_unit.sv
// tb_tis_acc_unit: directed bench with an expected-result scoreboard
// and a small saturating ACC/BAK reference model.
module tb_tis_acc_unit;
  localparam int N = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [2:0]   op = '0;
  logic         src_imm = 1'b0;
  logic [0:N-1] imm = '0;
  logic [0:N-1] port_data = '0;
  logic         port_valid = 1'b0;
  logic         port_ready;
  logic [0:N-1] acc;
  logic         flag_z, flag_n, flag_p;
  logic         done;

  tis_acc_unit #(.N(N), .LIMIT(999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .src_imm    (src_imm),
    .imm        (imm),
    .port_data  (port_data),
    .port_valid (port_valid),
    .port_ready (port_ready),
    .acc        (acc),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_p     (flag_p),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   m_acc = 0;
  int   m_bak = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clampf(input int x);
    if (x > 999) return 999;
    if (x < -999) return -999;
    return x;
  endfunction

  // Issue one op; for port ops, hold port_valid low for pd cycles first.
  task automatic do_op(input string tag, input logic [2:0] o,
                       input bit si, input int v, input int pd);
    exp_t e;
    int   idx;
    int   w;
    bit   port_op;
    port_op = !si && (o == 3'b001 || o == 3'b010 || o == 3'b011);
    case (o)
      3'b001:  m_acc = clampf(v);
      3'b010:  m_acc = clampf(m_acc + v);
      3'b011:  m_acc = clampf(m_acc - v);
      3'b100:  m_acc = -m_acc;
      3'b101:  begin w = m_acc; m_acc = m_bak; m_bak = w; end
      3'b110:  m_bak = m_acc;
      default: ;
    endcase
    e.acc = m_acc;
    e.lat = port_op ? pd + 2 : 1;
    sb.push_back(e);

    w = 0;
    while (!op_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    op_valid = 1'b1;
    op       = o;
    src_imm  = si;
    imm      = port_op ? 11'($urandom) : 11'(v);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op       = 3'($urandom);
    imm      = 11'($urandom);
    src_imm  = 1'($urandom);
    idx = -1;
    if (port_op) begin
      for (int j = 0; j < pd; j++) begin
        op_valid = 1'b1;
        op       = 3'b100;
        @(negedge clk);
        idx++;
        chk({tag, "_port_ready_wait"}, port_ready, 1);
        chk({tag, "_op_ready_wait"}, op_ready, 0);
      end
      @(negedge clk);
      idx++;
      op_valid   = 1'b0;
      chk({tag, "_port_ready"}, port_ready, 1);
      port_data  = 11'(v);
      port_valid = 1'b1;
      @(posedge clk);
      #1;
      port_valid = 1'b0;
      port_data  = 11'($urandom);
    end
    while (idx < 60) begin
      @(negedge clk);
      idx++;
      if (done) break;
    end
    chk({tag, "_done_seen"}, done, 1);
    e = sb.pop_front();
    chk({tag, "_acc"}, $signed(acc), e.acc);
    chk({tag, "_latency"}, idx, e.lat);
    chk({tag, "_flag_z"}, flag_z, e.acc == 0);
    chk({tag, "_flag_n"}, flag_n, e.acc < 0);
    chk({tag, "_flag_p"}, flag_p, e.acc > 0);
    chk({tag, "_op_ready_at_done"}, op_ready, 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_acc", $signed(acc), 0);
    chk("rst_flag_z", flag_z, 1);
    chk("rst_flag_n", flag_n, 0);
    chk("rst_flag_p", flag_p, 0);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_port_ready", port_ready, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mov5", 3'b001, 1'b1, 5, 0);
    do_op("add7", 3'b010, 1'b1, 7, 0);
    do_op("mov900", 3'b001, 1'b1, 900, 0);
    do_op("add500_sat", 3'b010, 1'b1, 500, 0);
    do_op("sub_m999_sat", 3'b011, 1'b1, -999, 0);
    do_op("sub999_a", 3'b011, 1'b1, 999, 0);
    do_op("sub999_b", 3'b011, 1'b1, 999, 0);
    do_op("sub999_sat", 3'b011, 1'b1, 999, 0);
    do_op("movp_1023", 3'b001, 1'b0, 1023, 0);
    do_op("movp_m1024", 3'b001, 1'b0, -1024, 0);
    do_op("mov9", 3'b001, 1'b1, 9, 0);
    do_op("addp3_wait5", 3'b010, 1'b0, 3, 5);

    // Reset while parked in WAIT_PORT with ACC=12
    op_valid = 1'b1;
    op       = 3'b010;
    src_imm  = 1'b0;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_port_ready", port_ready, 1);
    chk("midrst_pre_acc", $signed(acc), 12);
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", $signed(acc), 0);
    chk("midrst_port_ready", port_ready, 0);
    chk("midrst_op_ready", op_ready, 1);
    chk("midrst_flag_z", flag_z, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0;
    m_bak = 0;
    port_data  = 11'(5);
    port_valid = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) n++;
    end
    port_valid = 1'b0;
    chk("midrst_no_done", n, 0);
    chk("midrst_acc_hold", $signed(acc), 0);

    do_op("mov1", 3'b001, 1'b1, 1, 0);
    do_op("mov42", 3'b001, 1'b1, 42, 0);
    do_op("sav", 3'b110, 1'b1, 0, 0);
    do_op("mov_m7", 3'b001, 1'b1, -7, 0);
    do_op("swp1", 3'b101, 1'b1, 0, 0);
    do_op("swp2", 3'b101, 1'b1, 0, 0);
    do_op("neg", 3'b100, 1'b1, 0, 0);
    do_op("neg_back", 3'b100, 1'b0, 0, 0);
    do_op("mov0", 3'b001, 1'b1, 0, 0);
    do_op("op111", 3'b111, 1'b1, 123, 0);
    do_op("nop", 3'b000, 1'b0, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
